// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encodings, error causes and helpers for instruction fetch.
// Revision: 1.0
`default_nettype none

package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_VALID = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ERR   = 3'd4
   } fetch_state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_timer.sv
// fetch_timer: request age counter; expired flags the last allowed unacknowledged cycle.
// Revision: 1.0
`default_nettype none

module fetch_timer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rest,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC-to-imem fetches, holds the PC, drops stale returns, reports fetch errors.
// Revision: 1.0
`default_nettype none

module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rest,
   input  logic [31:0] pc_addr,
   input  logic        flush,
   input  logic        stall,
   output logic        pc_hold,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] inst_addr,
   output logic        fetch_err,
   output logic [1:0]  err_cause,
   output logic [31:0] err_addr
);

   fetch_state_t state;
   logic         aligned;
   logic         tmr_clear;
   logic         tmr_en;
   logic         tmr_expired;

   assign aligned   = word_aligned(pc_addr[1:0]);
   assign imem_addr = pc_addr;
   assign imem_req  = (state == ST_REQ) && aligned;
   assign pc_hold   = !rest ? 1'b1 : !(flush || ((state == ST_VALID) && !stall));

   // Any exit from REQ, and a flush+ack re-entry, restart the request age.
   assign tmr_clear = (state != ST_REQ) || flush || imem_ack;
   assign tmr_en    = (state == ST_REQ) && aligned;

   fetch_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rest    (rest),
      .clear   (tmr_clear),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state      <= ST_IDLE;
         inst       <= '0;
         inst_addr  <= '0;
         inst_valid <= 1'b0;
         fetch_err  <= 1'b0;
         err_cause  <= ERR_NONE;
         err_addr   <= '0;
      end else begin
         fetch_err <= 1'b0;
         unique case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (flush) begin
                  // Only an issued, unanswered request leaves a return to drain.
                  state <= (imem_ack || !aligned) ? ST_REQ : ST_DRAIN;
               end else if (!aligned) begin
                  state     <= ST_ERR;
                  fetch_err <= 1'b1;
                  err_cause <= ERR_MISALIGN;
                  err_addr  <= pc_addr;
               end else if (imem_ack) begin
                  state      <= ST_VALID;
                  inst       <= imem_rdata;
                  inst_addr  <= pc_addr;
                  inst_valid <= 1'b1;
               end else if (tmr_expired) begin
                  state     <= ST_ERR;
                  fetch_err <= 1'b1;
                  err_cause <= ERR_TIMEOUT;
                  err_addr  <= pc_addr;
               end
            end
            ST_VALID: begin
               if (flush || !stall) begin
                  state      <= ST_REQ;
                  inst_valid <= 1'b0;
               end
            end
            ST_DRAIN: if (imem_ack) state <= ST_REQ;
            ST_ERR:   if (flush) state <= ST_REQ;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus async-reset sequence for fetch_ctrl.
// Revision: 1.0
`default_nettype none

module tb_fetch_ctrl;

   logic        clk;
   logic        rest;
   logic [31:0] pc_addr;
   logic        flush;
   logic        stall;
   logic        pc_hold;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] inst_addr;
   logic        fetch_err;
   logic [1:0]  err_cause;
   logic [31:0] err_addr;

   int n_pass;
   int n_total;

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        st;
      logic        ak;
      logic [31:0] rd;
      logic        hold;
      logic        req;
      logic        iv;
      logic [31:0] ins;
      logic [31:0] ia;
      logic        fe;
      logic [1:0]  ca;
      logic [31:0] ea;
   } vec_t;

   vec_t vecs[$];

   fetch_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk        (clk),
      .rest       (rest),
      .pc_addr    (pc_addr),
      .flush      (flush),
      .stall      (stall),
      .pc_hold    (pc_hold),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_addr  (inst_addr),
      .fetch_err  (fetch_err),
      .err_cause  (err_cause),
      .err_addr   (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t v(input logic [31:0] pc, input logic fl, input logic st,
                              input logic ak, input logic [31:0] rd, input logic hold,
                              input logic req, input logic iv, input logic [31:0] ins,
                              input logic [31:0] ia, input logic fe, input logic [1:0] ca,
                              input logic [31:0] ea);
      vec_t r;
      r.pc = pc; r.fl = fl; r.st = st; r.ak = ak; r.rd = rd;
      r.hold = hold; r.req = req; r.iv = iv; r.ins = ins; r.ia = ia;
      r.fe = fe; r.ca = ca; r.ea = ea;
      return r;
   endfunction

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [133:0] snap();
      return {imem_addr, pc_hold, imem_req, inst_valid, inst, inst_addr, fetch_err, err_cause, err_addr};
   endfunction

   task automatic drive(input logic [31:0] pc, input logic fl, input logic st,
                        input logic ak, input logic [31:0] rd);
      pc_addr = pc; flush = fl; stall = st; imem_ack = ak; imem_rdata = rd;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rest = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Reset release, first fetch at 0x0, then 0x4 with a three-cycle stall.
      vecs.push_back(v(32'h0, 0,0,0, 32'h0,        1,0,0, 32'h0, 32'h0, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h0, 0,0,0, 32'h0,        1,1,0, 32'h0, 32'h0, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h0, 0,0,1, 32'h2402000A, 1,1,0, 32'h0, 32'h0, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h0, 0,0,0, 32'h0,        0,0,1, 32'h2402000A, 32'h0, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h4, 0,0,0, 32'h0,        1,1,0, 32'h2402000A, 32'h0, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h4, 0,0,1, 32'h8C220004, 1,1,0, 32'h2402000A, 32'h0, 0,2'd0, 32'h0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(32'h4, 0,1,0, 32'h0,     1,0,1, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h4, 0,0,0, 32'h0,        0,0,1, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      // Flush with request outstanding, stale 0xDEADBEEF return discarded.
      vecs.push_back(v(32'h8,   1,0,0, 32'h0,        0,1,0, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h100, 0,0,0, 32'h0,        1,0,0, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h100, 0,0,1, 32'hDEADBEEF, 1,0,0, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h100, 0,0,0, 32'h0,        1,1,0, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h100, 0,0,1, 32'h24030005, 1,1,0, 32'h8C220004, 32'h4, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h100, 1,1,0, 32'h0,        0,0,1, 32'h24030005, 32'h100, 0,2'd0, 32'h0));
      // Sixteen unacknowledged cycles at 0x40 -> timeout.
      for (int i = 0; i < 16; i++)
         vecs.push_back(v(32'h40, 0,0,0, 32'h0,    1,1,0, 32'h24030005, 32'h100, 0,2'd0, 32'h0));
      vecs.push_back(v(32'h40, 0,0,0, 32'h0,        1,0,0, 32'h24030005, 32'h100, 1,2'd2, 32'h40));
      vecs.push_back(v(32'h40, 0,0,1, 32'hBADBAD00, 1,0,0, 32'h24030005, 32'h100, 0,2'd2, 32'h40));
      vecs.push_back(v(32'h40, 1,0,0, 32'h0,        0,0,0, 32'h24030005, 32'h100, 0,2'd2, 32'h40));
      vecs.push_back(v(32'h80000180, 0,0,1, 32'h42000018, 1,1,0, 32'h24030005, 32'h100, 0,2'd2, 32'h40));
      vecs.push_back(v(32'h80000180, 0,0,0, 32'h0, 0,0,1, 32'h42000018, 32'h80000180, 0,2'd2, 32'h40));
      // Misaligned PC 0x6.
      vecs.push_back(v(32'h6, 0,0,0, 32'h0, 1,0,0, 32'h42000018, 32'h80000180, 0,2'd2, 32'h40));
      vecs.push_back(v(32'h6, 0,0,0, 32'h0, 1,0,0, 32'h42000018, 32'h80000180, 1,2'd1, 32'h6));
      vecs.push_back(v(32'h6, 1,0,0, 32'h0, 0,0,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      // Flush with ack: data dropped, REQ re-entered with a fresh timer.
      vecs.push_back(v(32'h200, 1,0,1, 32'h11111111, 0,1,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      for (int i = 0; i < 15; i++)
         vecs.push_back(v(32'h300, 0,0,0, 32'h0, 1,1,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      // Flush on the timeout cycle: no error, drain instead; second flush while draining.
      vecs.push_back(v(32'h300, 1,0,0, 32'h0,        0,1,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      vecs.push_back(v(32'h400, 0,0,0, 32'h0,        1,0,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      vecs.push_back(v(32'h400, 1,0,0, 32'h0,        0,0,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      vecs.push_back(v(32'h400, 0,0,1, 32'h77777777, 1,0,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      vecs.push_back(v(32'h400, 0,0,1, 32'hAAAA5555, 1,1,0, 32'h42000018, 32'h80000180, 0,2'd1, 32'h6));
      vecs.push_back(v(32'h400, 0,0,0, 32'h0,        0,0,1, 32'hAAAA5555, 32'h400, 0,2'd1, 32'h6));

      repeat (2) @(negedge clk);
      #1;
      check("reset_state", snap(), {32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0});
      @(negedge clk);
      rest = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].pc, vecs[i].fl, vecs[i].st, vecs[i].ak, vecs[i].rd);
         #1;
         check($sformatf("vec%0d", i), snap(),
               {vecs[i].pc, vecs[i].hold, vecs[i].req, vecs[i].iv, vecs[i].ins, vecs[i].ia,
                vecs[i].fe, vecs[i].ca, vecs[i].ea});
      end

      // Asynchronous reset in the middle of a request.
      @(negedge clk);
      drive(32'h404, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      check("pre_reset_req", 134'({imem_req, inst_valid}), 134'(2'b10));
      #2;
      rest = 1'b0;
      #1;
      check("async_reset", 134'({pc_hold, imem_req, inst_valid, fetch_err, inst, inst_addr, err_cause, err_addr}),
            134'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0}));
      drive(32'h404, 1'b0, 1'b0, 1'b1, 32'h55555555);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("ack_in_reset", 134'({pc_hold, imem_req, inst_valid, fetch_err, inst}),
            134'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
      rest = 1'b1;
      #1;
      check("idle_after_release", 134'({pc_hold, imem_req, inst_valid, inst}),
            134'({1'b1, 1'b0, 1'b0, 32'h0}));
      @(negedge clk);
      drive(32'h404, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      check("req_after_release", 134'({pc_hold, imem_req, imem_addr, inst_valid, inst}),
            134'({1'b1, 1'b1, 32'h404, 1'b0, 32'h0}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch between the program counter and the instruction memory port. Issues one word request per instruction and waits for the memory acknowledge. Holds the PC while a fetch is in flight or while the decode stage stalls. Handles flushes from branch/jump/COP0 redirects, discards stale returns, and reports misaligned or timed-out fetches to COP0 as fetch errors.

Parameters:
TIMEOUT, 16, max cycles a request may stay unacknowledged before a timeout error (must be >= 2)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  core clock, all state on posedge
rest  input  1  reset, asynchronous, active-low (0 = reset)
pc_addr  input  32  current PC register value
flush  input  1  redirect this cycle; PC loads a non-sequential target at this edge
stall  input  1  decode cannot accept the held instruction
pc_hold  output  1  1 = PC must not update this cycle (gates PC register enable)
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address; always equal to pc_addr, qualified by imem_req
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched word
inst  output  32  registered instruction to decode
inst_valid  output  1  inst holds a live instruction
inst_addr  output  32  address inst was fetched from
fetch_err  output  1  one-cycle error pulse to COP0
err_cause  output  2  01 misaligned, 10 timeout, 00 otherwise
err_addr  output  32  faulting fetch address

Behaviour:
- Async reset (rest=0): state IDLE; counter 0; inst, inst_addr, err_addr = 0; inst_valid, fetch_err, imem_req = 0; err_cause = 00; pc_hold = 1.
- States: IDLE, REQ, VALID, DRAIN, ERR.
- imem_req = 1 only in REQ with pc_addr[1:0] == 00.
- pc_hold = 0 iff flush, or (state == VALID and !stall). Otherwise pc_hold = 1.
- IDLE: after reset release, move to REQ on the next edge. flush is ignored except for pc_hold.
- REQ entry: counter cleared.
  - pc_addr[1:0] != 00: no request. Next edge → ERR; fetch_err=1, err_cause=01, err_addr=pc_addr.
  - ack and !flush: inst <= imem_rdata, inst_addr <= pc_addr, inst_valid <= 1 → VALID. Minimum latency is 1 cycle from req to inst_valid.
  - flush with ack: data dropped → REQ (re-entered, counter cleared).
  - flush without ack: → DRAIN.
  - no ack, no flush: counter increments. If the counter reaches TIMEOUT-1, i.e. the TIMEOUT-th unacked cycle: → ERR; fetch_err=1, err_cause=10, err_addr=pc_addr.
- VALID: inst_valid=1.
  - !stall: instruction consumed; PC advances this edge; inst_valid <= 0 → REQ.
  - stall: hold inst and inst_valid unchanged.
  - flush (any stall value): inst_valid <= 0 → REQ.
- DRAIN: imem_req=0. Wait for the outstanding ack and discard its data.
  - ack → REQ.
  - A further flush in DRAIN keeps the state DRAIN and drops pc_hold to 0.
  - No timeout in DRAIN.
- ERR: imem_req=0, inst_valid=0. imem_ack is ignored. Stay until flush (COP0 redirect), then → REQ.
- fetch_err is high exactly one cycle, the first cycle in ERR. err_cause and err_addr hold until the next error or reset.
- Priority in the same cycle: flush > ack > timeout/misalign. Flush coinciding with the timeout cycle gives no error.
- Steady throughput with zero-wait memory: one instruction per 2 cycles.
- Reset mid-request: all state cleared at once. A late ack after reset is ignored because the block starts in IDLE.

Decomposition:
- The shared common.v header gets:
  - `define FETCH_ST_IDLE/REQ/VALID/DRAIN/ERR (3-bit encodings)
  - `define FETCH_ERR_NONE/MISALIGN/TIMEOUT (2-bit)
- One natural sub-module, fetch_timer: CNT_W counter with clear, enable and a `expired` output at TIMEOUT-1. fetch_ctrl holds the FSM and the output registers.

Test Plan:
- Reset release, pc_addr=0x0, ack one cycle after req with rdata=0x2402000A → inst=0x2402000A, inst_addr=0x0, inst_valid=1, pc_hold=0 in that VALID cycle. Next req at pc_addr=0x4.
- stall held 3 cycles in VALID → inst and inst_valid stable and pc_hold=1 for 3 cycles. Release stall → pc_hold=0 for one cycle, then REQ.
- flush in REQ with no ack, ack arrives 2 cycles later with 0xDEADBEEF → inst_valid stays 0, data discarded. Req then reissued at the new pc_addr=0x100.
- No ack for 16 cycles at pc_addr=0x40 → fetch_err pulses 1 cycle, err_cause=10, err_addr=0x40, req drops. flush, then pc_addr=0x80000180 → req at 0x80000180.
- pc_addr=0x6 entering REQ → no imem_req, fetch_err=1, err_cause=01, err_addr=0x6.
- rest=0 asserted mid-REQ, asynchronously → imem_req, inst_valid, fetch_err = 0 immediately. Ack during reset is ignored; after release, IDLE → REQ.
